pci_initiator_ctrl: RTL

PCI_INITIATOR_CTRL -- requirements
Module: pci_initiator_ctrl

---
 rtl/pci_pkg.sv | 23 ++
 rtl/pci_initiator_ctrl_if.sv | 24 ++
 rtl/pci_lat_timer.sv | 27 ++
 rtl/pci_initiator_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI initiator controller.
// Holds the FSM state type, timing constants and PCI bus command encodings.
package pci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    TURN
  } pci_state_t;

  localparam int unsigned LAT_TIMER_CYCLES = 16;
  localparam int unsigned DEVSEL_TIMEOUT   = 5;

  localparam logic [3:0] CMD_IO_READ   = 4'h2;
  localparam logic [3:0] CMD_IO_WRITE  = 4'h3;
  localparam logic [3:0] CMD_MEM_READ  = 4'h6;
  localparam logic [3:0] CMD_MEM_WRITE = 4'h7;
  localparam logic [3:0] CMD_CFG_READ  = 4'hA;
  localparam logic [3:0] CMD_CFG_WRITE = 4'hB;

endpackage

// File: rtl/pci_initiator_ctrl_if.sv
// PCI bus-side signals of the initiator: arbitration, sampled bus state and drives.
// master = the initiator controller, slave = the bus/arbiter/target side.
interface pci_initiator_ctrl_if;
  logic       GNT_n;
  logic       FRAME_in_n;
  logic       IRDY_in_n;
  logic       TRDY_n;
  logic       DEVSEL_n;
  logic       REQ_n;
  logic       FRAME_n;
  logic       IRDY_n;
  logic [3:0] cbe_n;
  logic       bus_oe;

  modport master (
    input  GNT_n, FRAME_in_n, IRDY_in_n, TRDY_n, DEVSEL_n,
    output REQ_n, FRAME_n, IRDY_n, cbe_n, bus_oe
  );

  modport slave (
    output GNT_n, FRAME_in_n, IRDY_in_n, TRDY_n, DEVSEL_n,
    input  REQ_n, FRAME_n, IRDY_n, cbe_n, bus_oe
  );
endinterface

// File: rtl/pci_lat_timer.sv
// Master latency timer: loaded at the address phase, counts down once per data cycle.
// Only instantiated when PCI_LATENCY_TIMER_EN is defined.
module pci_lat_timer
  import pci_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [7:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else if (load) begin
      count_reg <= 8'(LAT_TIMER_CYCLES);
    end else if (tick && count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign expired = (count_reg == 8'd0);

endmodule

// File: rtl/pci_initiator_ctrl.sv
// PCI initiator: arbitration, address phase, burst data phases, master abort, turnaround.
// Optional latency timer enabled with the PCI_LATENCY_TIMER_EN macro.
module pci_initiator_ctrl
  import pci_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          cmd,
  input  logic [2:0]          len,
  pci_initiator_ctrl_if.master bus,
  output logic                busy,
  output logic                data_ack,
  output logic                done,
  output logic                abort
);

  localparam logic [2:0] DEVSEL_LAST = 3'(DEVSEL_TIMEOUT - 1);

  pci_state_t state_reg, state_next;
  logic [3:0] cmd_reg, cmd_next;
  logic [3:0] remaining_reg, remaining_next;
  logic [2:0] devsel_cnt_reg, devsel_cnt_next;
  logic       devsel_seen_reg, devsel_seen_next;
  logic       aborting_reg, aborting_next;
  logic       req_n_reg, req_n_next;
  logic       frame_n_reg, frame_n_next;
  logic       irdy_n_reg, irdy_n_next;
  logic [3:0] cbe_n_reg, cbe_n_next;
  logic       bus_oe_reg, bus_oe_next;
  logic       busy_reg, busy_next;
  logic       data_ack_reg, data_ack_next;
  logic       done_reg, done_next;
  logic       abort_reg, abort_next;

`ifdef PCI_LATENCY_TIMER_EN
  logic lat_expired;

  pci_lat_timer u_lat_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_reg == ADDR),
    .tick    (state_reg == DATA),
    .expired (lat_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cmd_reg         <= 4'd0;
      remaining_reg   <= 4'd0;
      devsel_cnt_reg  <= 3'd0;
      devsel_seen_reg <= 1'b0;
      aborting_reg    <= 1'b0;
      req_n_reg       <= 1'b1;
      frame_n_reg     <= 1'b1;
      irdy_n_reg      <= 1'b1;
      cbe_n_reg       <= 4'hF;
      bus_oe_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      data_ack_reg    <= 1'b0;
      done_reg        <= 1'b0;
      abort_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cmd_reg         <= cmd_next;
      remaining_reg   <= remaining_next;
      devsel_cnt_reg  <= devsel_cnt_next;
      devsel_seen_reg <= devsel_seen_next;
      aborting_reg    <= aborting_next;
      req_n_reg       <= req_n_next;
      frame_n_reg     <= frame_n_next;
      irdy_n_reg      <= irdy_n_next;
      cbe_n_reg       <= cbe_n_next;
      bus_oe_reg      <= bus_oe_next;
      busy_reg        <= busy_next;
      data_ack_reg    <= data_ack_next;
      done_reg        <= done_next;
      abort_reg       <= abort_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cmd_next         = cmd_reg;
    remaining_next   = remaining_reg;
    devsel_cnt_next  = devsel_cnt_reg;
    devsel_seen_next = devsel_seen_reg;
    aborting_next    = aborting_reg;
    req_n_next       = req_n_reg;
    frame_n_next     = frame_n_reg;
    irdy_n_next      = irdy_n_reg;
    cbe_n_next       = cbe_n_reg;
    bus_oe_next      = bus_oe_reg;
    busy_next        = busy_reg;
    data_ack_next    = 1'b0;
    done_next        = 1'b0;
    abort_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cmd_next       = cmd;
          remaining_next = {1'b0, len} + 4'd1;
          req_n_next     = 1'b0;
          busy_next      = 1'b1;
          state_next     = REQ;
        end
      end
      REQ: begin
        // Bus must be idle (no FRAME, no IRDY) in the same cycle the grant is seen.
        if (!bus.GNT_n && bus.FRAME_in_n && bus.IRDY_in_n) begin
          frame_n_next = 1'b0;
          irdy_n_next  = 1'b1;
          cbe_n_next   = cmd_reg;
          bus_oe_next  = 1'b1;
          state_next   = ADDR;
        end
      end
      ADDR: begin
        irdy_n_next      = 1'b0;
        cbe_n_next       = 4'b0000;
        frame_n_next     = (remaining_reg == 4'd1);
        devsel_cnt_next  = 3'd0;
        devsel_seen_next = 1'b0;
        aborting_next    = 1'b0;
        state_next       = DATA;
      end
      DATA: begin
        if (aborting_reg) begin
          irdy_n_next = 1'b1;
          req_n_next  = 1'b1;
          cbe_n_next  = 4'hF;
          abort_next  = 1'b1;
          state_next  = TURN;
        end else if (bus.DEVSEL_n && !devsel_seen_reg && devsel_cnt_reg == DEVSEL_LAST) begin
          // No target claimed the cycle: release FRAME now, IRDY a cycle later.
          frame_n_next  = 1'b1;
          aborting_next = 1'b1;
        end else begin
          if (!bus.DEVSEL_n) begin
            devsel_seen_next = 1'b1;
          end else if (!devsel_seen_reg) begin
            devsel_cnt_next = devsel_cnt_reg + 3'd1;
          end
          if (!bus.TRDY_n) begin
            data_ack_next  = 1'b1;
            remaining_next = remaining_reg - 4'd1;
            if (remaining_reg == 4'd1) begin
              frame_n_next = 1'b1;
              irdy_n_next  = 1'b1;
              req_n_next   = 1'b1;
              cbe_n_next   = 4'hF;
              done_next    = 1'b1;
              state_next   = TURN;
            end else if (remaining_reg == 4'd2) begin
              frame_n_next = 1'b1;
            end
          end
`ifdef PCI_LATENCY_TIMER_EN
          // Timer expired with grant gone: the phase in flight becomes the last one.
          if (lat_expired && bus.GNT_n && !frame_n_reg && remaining_reg > 4'd1) begin
            frame_n_next   = 1'b1;
            remaining_next = 4'd1;
          end
`endif
        end
      end
      TURN: begin
        frame_n_next = 1'b1;
        irdy_n_next  = 1'b1;
        cbe_n_next   = 4'hF;
        bus_oe_next  = 1'b0;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.REQ_n   = req_n_reg;
  assign bus.FRAME_n = frame_n_reg;
  assign bus.IRDY_n  = irdy_n_reg;
  assign bus.cbe_n   = cbe_n_reg;
  assign bus.bus_oe  = bus_oe_reg;
  assign busy        = busy_reg;
  assign data_ack    = data_ack_reg;
  assign done        = done_reg;
  assign abort       = abort_reg;

endmodule
